// File: rtl/decode_issue_stage.sv
// decode_issue_stage: DLX decode/issue with register file, load-use interlock, in-ID branches, halt and debug read
module decode_issue_stage #(
    parameter int NB_DATA         = 32,
    parameter int NB_REG          = 5,
    parameter int ADDRWIDTH       = 10,
    parameter int LOAD_USE_STALLS = 1
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_enable,
    input  logic [NB_DATA-1:0]   i_instruction,
    input  logic [ADDRWIDTH-1:0] i_pc,
    input  logic                 i_wb_write,
    input  logic [NB_REG-1:0]    i_wb_reg,
    input  logic [NB_DATA-1:0]   i_wb_data,
    input  logic                 i_ex_mem_read,
    input  logic [NB_REG-1:0]    i_ex_rt,
    input  logic                 i_fwd_a,
    input  logic                 i_fwd_b,
    input  logic [NB_DATA-1:0]   i_fwd_data,
    input  logic                 i_dbg_req,
    input  logic [NB_REG-1:0]    i_dbg_addr,
    output logic                 o_dbg_ack,
    output logic [NB_DATA-1:0]   o_dbg_data,
    output logic                 o_pc_write,
    output logic                 o_if_id_write,
    output logic                 o_take_branch,
    output logic [ADDRWIDTH-1:0] o_target,
    output logic                 o_valid,
    output logic [NB_REG-1:0]    o_rs,
    output logic [NB_REG-1:0]    o_rt,
    output logic [NB_REG-1:0]    o_rd,
    output logic [4:0]           o_shamt,
    output logic [5:0]           o_funct,
    output logic [NB_DATA-1:0]   o_imm_ext,
    output logic [NB_DATA-1:0]   o_data_a,
    output logic [NB_DATA-1:0]   o_data_b,
    output logic                 o_reg_write,
    output logic                 o_mem_read,
    output logic                 o_mem_write,
    output logic                 o_alu_imm,
    output logic                 o_reg_dst,
    output logic                 o_halt
);
    typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;
    localparam logic [2:0] CNT_INIT = 3'(LOAD_USE_STALLS - 1);

    state_t             state, state_next;
    logic [2:0]         cnt, cnt_next;
    logic [NB_DATA-1:0] rf [2**NB_REG];

    logic [5:0]         opcode;
    logic [NB_REG-1:0]  rs, rt;
    logic [NB_DATA-1:0] imm_ext, data_a, data_b, dbg_val, op_a, op_b;
    logic is_r, is_lw, is_sw, is_beq, is_bne, is_j, is_halt, is_alui;
    logic hz, can_run, issue, dbg_svc;

    assign opcode  = i_instruction[31:26];
    assign rs      = i_instruction[21 +: NB_REG];
    assign rt      = i_instruction[16 +: NB_REG];
    assign imm_ext = {{(NB_DATA-16){i_instruction[15]}}, i_instruction[15:0]};

    assign is_r    = opcode == 6'h00;
    assign is_lw   = opcode == 6'h23;
    assign is_sw   = opcode == 6'h2B;
    assign is_beq  = opcode == 6'h04;
    assign is_bne  = opcode == 6'h05;
    assign is_j    = opcode == 6'h02;
    assign is_halt = opcode == 6'h3F;
    assign is_alui = !(is_r || is_lw || is_sw || is_beq || is_bne || is_j || is_halt);

    // r0 never holds data, so it must also escape the write-through path
    assign data_a  = rs == '0 ? '0 : (i_wb_write && i_wb_reg == rs) ? i_wb_data : rf[rs];
    assign data_b  = rt == '0 ? '0 : (i_wb_write && i_wb_reg == rt) ? i_wb_data : rf[rt];
    assign dbg_val = i_dbg_addr == '0 ? '0 : (i_wb_write && i_wb_reg == i_dbg_addr) ? i_wb_data : rf[i_dbg_addr];

    assign hz = i_ex_mem_read && i_ex_rt != '0 &&
                (i_ex_rt == rs || (i_ex_rt == rt && (is_r || is_sw || is_beq || is_bne)));

    // The last stall cycle (cnt==0) already behaves as RUN so exactly LOAD_USE_STALLS bubbles result
    assign can_run = state == RUN || (state == STALL && cnt == '0);
    assign issue   = i_enable && can_run && !hz;

    assign op_a          = i_fwd_a ? i_fwd_data : data_a;
    assign op_b          = i_fwd_b ? i_fwd_data : data_b;
    assign o_take_branch = issue && ((is_beq && op_a == op_b) || (is_bne && op_a != op_b) || is_j);
    assign o_target      = is_j ? i_instruction[ADDRWIDTH-1:0] : i_pc + imm_ext[ADDRWIDTH-1:0];
    assign o_pc_write    = issue;
    assign o_if_id_write = issue;
    assign dbg_svc       = i_dbg_req && !o_dbg_ack && (state == HALTED || !i_enable);

    // Next state: stall on load-use, stick in HALTED after issuing HALT, freeze while disabled
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        if (i_enable && can_run) begin
            state_next = hz ? STALL : is_halt ? HALTED : RUN;
            cnt_next   = hz ? CNT_INIT : cnt;
        end else if (i_enable && state == STALL) begin
            cnt_next = cnt - 3'd1;
        end
    end

    // State and stall counter registers
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Register file; writes continue even while the stage is frozen
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            for (int i = 0; i < 2**NB_REG; i++) rf[i] <= '0;
        end else if (i_wb_write && i_wb_reg != '0) begin
            rf[i_wb_reg] <= i_wb_data;
        end
    end

    // ID/EX latch: real instruction on issue, bubble otherwise, hold when disabled
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_valid     <= 1'b0;
            o_rs        <= '0;
            o_rt        <= '0;
            o_rd        <= '0;
            o_shamt     <= '0;
            o_funct     <= '0;
            o_imm_ext   <= '0;
            o_data_a    <= '0;
            o_data_b    <= '0;
            o_reg_write <= 1'b0;
            o_mem_read  <= 1'b0;
            o_mem_write <= 1'b0;
            o_alu_imm   <= 1'b0;
            o_reg_dst   <= 1'b0;
            o_halt      <= 1'b0;
        end else if (i_enable) begin
            o_valid     <= issue;
            o_rs        <= rs;
            o_rt        <= rt;
            o_rd        <= i_instruction[11 +: NB_REG];
            o_shamt     <= i_instruction[10:6];
            o_funct     <= i_instruction[5:0];
            o_imm_ext   <= imm_ext;
            o_data_a    <= data_a;
            o_data_b    <= data_b;
            o_reg_write <= issue && (is_r || is_lw || is_alui);
            o_mem_read  <= issue && is_lw;
            o_mem_write <= issue && is_sw;
            o_alu_imm   <= issue && (is_lw || is_sw || is_alui);
            o_reg_dst   <= issue && is_r;
            o_halt      <= issue && is_halt;
        end
    end

    // Debug read: latch the register and pulse ack once the pipeline is quiet
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            o_dbg_ack  <= 1'b0;
            o_dbg_data <= '0;
        end else begin
            o_dbg_ack  <= dbg_svc;
            o_dbg_data <= dbg_svc ? dbg_val : o_dbg_data;
        end
    end
endmodule

// File: tb/tb_decode_issue_stage.sv
// tb_decode_issue_stage: directed self-checking bench for decode_issue_stage
module tb_decode_issue_stage;
    logic        i_clock = 1'b0;
    logic        i_reset, i_enable, i_wb_write, i_ex_mem_read, i_fwd_a, i_fwd_b, i_dbg_req;
    logic [31:0] i_instruction, i_wb_data, i_fwd_data;
    logic [9:0]  i_pc;
    logic [4:0]  i_wb_reg, i_ex_rt, i_dbg_addr;
    logic        o_dbg_ack, o_pc_write, o_if_id_write, o_take_branch, o_valid;
    logic [31:0] o_dbg_data, o_imm_ext, o_data_a, o_data_b;
    logic [9:0]  o_target;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic [5:0]  o_funct;
    logic        o_reg_write, o_mem_read, o_mem_write, o_alu_imm, o_reg_dst, o_halt;
    int checks = 0;
    int errors = 0;

    decode_issue_stage #(.NB_DATA(32), .NB_REG(5), .ADDRWIDTH(10), .LOAD_USE_STALLS(3)) dut (
        .i_clock(i_clock), .i_reset(i_reset), .i_enable(i_enable), .i_instruction(i_instruction),
        .i_pc(i_pc), .i_wb_write(i_wb_write), .i_wb_reg(i_wb_reg), .i_wb_data(i_wb_data),
        .i_ex_mem_read(i_ex_mem_read), .i_ex_rt(i_ex_rt), .i_fwd_a(i_fwd_a), .i_fwd_b(i_fwd_b),
        .i_fwd_data(i_fwd_data), .i_dbg_req(i_dbg_req), .i_dbg_addr(i_dbg_addr),
        .o_dbg_ack(o_dbg_ack), .o_dbg_data(o_dbg_data), .o_pc_write(o_pc_write),
        .o_if_id_write(o_if_id_write), .o_take_branch(o_take_branch), .o_target(o_target),
        .o_valid(o_valid), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
        .o_funct(o_funct), .o_imm_ext(o_imm_ext), .o_data_a(o_data_a), .o_data_b(o_data_b),
        .o_reg_write(o_reg_write), .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_alu_imm(o_alu_imm), .o_reg_dst(o_reg_dst), .o_halt(o_halt)
    );

    always #5 i_clock = ~i_clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    function automatic logic [31:0] r_ins(input logic [4:0] rs, rt, rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    initial begin
        i_reset = 1; i_enable = 1; i_instruction = '0; i_pc = '0;
        i_wb_write = 0; i_wb_reg = '0; i_wb_data = '0; i_ex_mem_read = 0; i_ex_rt = '0;
        i_fwd_a = 0; i_fwd_b = 0; i_fwd_data = '0; i_dbg_req = 0; i_dbg_addr = '0;
        tick(); tick();
        chk("rst_valid", 32'(o_valid), 0);
        chk("rst_regwrite", 32'(o_reg_write), 0);
        chk("rst_data_a", o_data_a, 0);
        chk("rst_dbg_ack", 32'(o_dbg_ack), 0);
        i_reset = 0;
        // ADDI r1,r0,5
        i_instruction = i_ins(6'h08, 5'd0, 5'd1, 16'd5);
        #1 chk("addi_pcw", 32'(o_pc_write), 1);
        tick();
        chk("addi_valid", 32'(o_valid), 1);
        chk("addi_regwrite", 32'(o_reg_write), 1);
        chk("addi_aluimm", 32'(o_alu_imm), 1);
        chk("addi_regdst", 32'(o_reg_dst), 0);
        chk("addi_imm", o_imm_ext, 5);
        i_instruction = r_ins(5'd0, 5'd0, 5'd0, 6'h20);
        i_wb_write = 1; i_wb_reg = 5'd1; i_wb_data = 32'd5;
        tick();
        i_wb_write = 0;
        i_instruction = i_ins(6'h2B, 5'd0, 5'd1, 16'd0);
        tick();
        chk("sw_data_b", o_data_b, 5);
        chk("sw_memwrite", 32'(o_mem_write), 1);
        chk("sw_regwrite", 32'(o_reg_write), 0);
        // write-through bypass
        i_wb_write = 1; i_wb_reg = 5'd4; i_wb_data = 32'h44;
        i_instruction = i_ins(6'h2B, 5'd0, 5'd4, 16'd0);
        tick();
        chk("bypass_data_b", o_data_b, 32'h44);
        // write to r0 ignored, including bypass
        i_wb_reg = 5'd0; i_wb_data = 32'd7;
        i_instruction = i_ins(6'h2B, 5'd0, 5'd0, 16'd0);
        tick();
        i_wb_write = 0;
        chk("r0_bypass", o_data_b, 0);
        i_instruction = i_ins(6'h2B, 5'd0, 5'd0, 16'd0);
        tick();
        chk("r0_read", o_data_b, 0);
        // I-type rt match is not a hazard
        i_ex_mem_read = 1; i_ex_rt = 5'd1;
        i_instruction = i_ins(6'h08, 5'd0, 5'd1, 16'd1);
        #1 chk("itype_nohz", 32'(o_pc_write), 1);
        // load-use: ADD r3,r2,r1 with LW r2 in EX
        i_ex_rt = 5'd2;
        i_instruction = r_ins(5'd2, 5'd1, 5'd3, 6'h20);
        #1 chk("hz_pcw0", 32'(o_pc_write), 0);
        chk("hz_ifid0", 32'(o_if_id_write), 0);
        tick();
        i_ex_mem_read = 0;
        chk("hz_bub1", 32'(o_valid), 0);
        chk("hz_st_pcw1", 32'(o_pc_write), 0);
        tick();
        chk("hz_bub2", 32'(o_valid), 0);
        chk("hz_st_pcw2", 32'(o_pc_write), 0);
        tick();
        chk("hz_bub3", 32'(o_valid), 0);
        chk("hz_resume_pcw", 32'(o_pc_write), 1);
        tick();
        chk("add_valid", 32'(o_valid), 1);
        chk("add_regdst", 32'(o_reg_dst), 1);
        chk("add_rd", 32'(o_rd), 3);
        // BEQ with forwarded A=9, rt(r6)=9 via bypass
        i_wb_write = 1; i_wb_reg = 5'd6; i_wb_data = 32'd9;
        i_fwd_a = 1; i_fwd_data = 32'd9; i_pc = 10'h10;
        i_instruction = i_ins(6'h04, 5'd7, 5'd6, 16'hFFFC);
        #1 chk("beq_take", 32'(o_take_branch), 1);
        chk("beq_target", 32'(o_target), 32'h0C);
        i_wb_data = 32'd8;
        #1 chk("beq_nottake", 32'(o_take_branch), 0);
        i_instruction = i_ins(6'h05, 5'd7, 5'd6, 16'hFFFC);
        #1 chk("bne_take", 32'(o_take_branch), 1);
        tick();
        chk("br_noctl", 32'(o_reg_write | o_mem_write | o_alu_imm), 0);
        i_wb_write = 0; i_fwd_a = 0;
        // J 0x3FF
        i_instruction = {6'h02, 26'h3FF};
        i_enable = 0;
        #1 chk("j_dis_take", 32'(o_take_branch), 0);
        chk("j_dis_pcw", 32'(o_pc_write), 0);
        tick();
        chk("freeze_valid", 32'(o_valid), 1);
        i_enable = 1;
        #1 chk("j_take", 32'(o_take_branch), 1);
        chk("j_target", 32'(o_target), 32'h3FF);
        tick();
        // load r5 then HALT
        i_wb_write = 1; i_wb_reg = 5'd5; i_wb_data = 32'hDEADBEEF;
        i_instruction = 32'hFC000000;
        tick();
        i_wb_write = 0;
        chk("halt_pulse", 32'(o_halt), 1);
        chk("halt_valid", 32'(o_valid), 1);
        i_instruction = r_ins(5'd1, 5'd1, 5'd2, 6'h20);
        #1 chk("halted_pcw", 32'(o_pc_write), 0);
        tick();
        chk("halt_drop", 32'(o_halt), 0);
        chk("halted_valid", 32'(o_valid), 0);
        i_dbg_req = 1; i_dbg_addr = 5'd5;
        tick();
        chk("dbg_ack", 32'(o_dbg_ack), 1);
        chk("dbg_data", o_dbg_data, 32'hDEADBEEF);
        i_dbg_req = 0;
        tick();
        chk("dbg_ack_pulse", 32'(o_dbg_ack), 0);
        chk("halted_sticky", 32'(o_valid), 0);
        // reset in HALTED with a pending request
        i_dbg_req = 1; i_reset = 1;
        tick();
        chk("rst2_ack", 32'(o_dbg_ack), 0);
        chk("rst2_valid", 32'(o_valid), 0);
        chk("rst2_halt", 32'(o_halt), 0);
        i_reset = 0;
        #1 chk("rst2_run_pcw", 32'(o_pc_write), 1);
        tick();
        chk("run_dbg_pending", 32'(o_dbg_ack), 0);
        i_enable = 0;
        tick();
        chk("dis_dbg_ack", 32'(o_dbg_ack), 1);
        chk("dis_dbg_data", o_dbg_data, 0);
        i_dbg_req = 0;
        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_issue_stage.md
# decode_issue_stage

Parametrised instruction-decode/issue stage for the MIPS-DLX pipeline, placed between the IF/ID latch and the execute stage. It contains:
- a 2^NB_REG-entry register file with write-through bypass and a hardwired-zero r0,
- a fixed-opcode control decoder,
- in-ID branch/jump resolution with EX/MEM forwarding,
- a counter-based load-use interlock for multi-cycle data memories,
- a sticky halt state machine,
- a req/ack debug register-read port.

All ID/EX outputs, including operand data, are registered.

## Interface
Parameters:
- NB_DATA, 32, register/operand width
- NB_REG, 5, register index width; file depth 2^NB_REG
- ADDRWIDTH, 10, instruction-address width
- LOAD_USE_STALLS, 1, bubbles inserted per load-use hazard (1..7)

Ports (the clock is i_clock; reset is i_reset, synchronous and active-high; one clock domain):
- i_clock  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_enable  in  1  stage advance enable
- i_instruction  in  NB_DATA  IF/ID instruction
- i_pc  in  ADDRWIDTH  IF/ID PC+1 (word address)
- i_wb_write  in  1  register-file write strobe
- i_wb_reg  in  NB_REG  write index
- i_wb_data  in  NB_DATA  write data
- i_ex_mem_read  in  1  instruction in EX is a load
- i_ex_rt  in  NB_REG  load destination in EX
- i_fwd_a, i_fwd_b  in  1 each  select i_fwd_data for branch compare operand A/B
- i_fwd_data  in  NB_DATA  EX/MEM forwarded value
- i_dbg_req  in  1  debug read request
- i_dbg_addr  in  NB_REG  debug register index
- o_dbg_ack  out  1  one-cycle debug read completion pulse
- o_dbg_data  out  NB_DATA  debug read value, valid with o_dbg_ack
- o_pc_write  out  1  PC update enable (combinational)
- o_if_id_write  out  1  IF/ID update enable (combinational)
- o_take_branch  out  1  redirect fetch (combinational)
- o_target  out  ADDRWIDTH  redirect address (combinational)
- o_valid  out  1  ID/EX holds a real instruction
- o_rs, o_rt, o_rd  out  NB_REG  register fields
- o_shamt  out  5  shift amount field
- o_funct  out  6  function field
- o_imm_ext  out  NB_DATA  sign-extended imm[15:0]
- o_data_a, o_data_b  out  NB_DATA  read data for rs/rt
- o_reg_write, o_mem_read, o_mem_write, o_alu_imm, o_reg_dst  out  1 each  control bits
- o_halt  out  1  HALT instruction in ID/EX

## Operation
Decode, by opcode = instr[31:26]:
- 0x00 R-type: reg_write=1, reg_dst=1.
- 0x23 LW: reg_write, mem_read, alu_imm.
- 0x2B SW: mem_write, alu_imm.
- 0x04 BEQ / 0x05 BNE: branch; no control bits set.
- 0x02 J: jump to instr[ADDRWIDTH-1:0].
- 0x3F HALT: no control bits set.
- Any other opcode: I-type ALU with reg_write=1, alu_imm=1, reg_dst=0.

Register file:
- Reading r0 returns 0; writes to r0 are ignored.
- If i_wb_write is high and i_wb_reg matches a read index in the same cycle, the read returns i_wb_data.

Hazard detection (load-use):
- hz = i_ex_mem_read & i_ex_rt≠0 & (i_ex_rt==rs | (i_ex_rt==rt & opcode ∈ {R, SW, BEQ, BNE})).

State machine:
- RUN:
  - hz=1: enter STALL with cnt=LOAD_USE_STALLS−1. This cycle a bubble is loaded into ID/EX, and o_pc_write=o_if_id_write=0.
  - HALT decoded: the HALT is issued with o_valid=1, o_halt=1, then enter HALTED.
- STALL:
  - A bubble is loaded each cycle; pc/if_id writes are held at 0.
  - If cnt==0, return to RUN and re-evaluate hz; otherwise cnt−−.
- HALTED:
  - Sticky until reset. Bubbles are loaded into ID/EX; pc/if_id writes are 0.
- A bubble clears o_valid, all control bits and o_halt. Field registers may hold any value.
- i_enable=0 freezes the ID/EX registers, the state and cnt, and forces pc/if_id writes to 0. Register-file writes still occur.

Branch/jump (RUN only, hz=0, i_enable=1):
- Operands: A = i_fwd_a ? i_fwd_data : rs data; B likewise with i_fwd_b.
- o_take_branch = (BEQ & A==B) | (BNE & A≠B) | J.
- o_target = J ? instr[ADDRWIDTH-1:0] : i_pc + imm_ext[ADDRWIDTH-1:0], modulo 2^ADDRWIDTH.
- o_take_branch is forced to 0 in STALL, in HALTED, when hz=1, or when i_enable=0.

Debug read:
- A request is serviced only in HALTED or while i_enable=0.
- Service: o_dbg_data is latched from the file at i_dbg_addr, and o_dbg_ack pulses on the next edge.
- A request made while running is held pending; i_dbg_req must stay high until ack.
- After ack, i_dbg_req must drop for at least one cycle before the next request.

## Timing
- Reset: state=RUN, cnt=0, all registered outputs 0, o_dbg_ack=0, all registers 0.
- Issue latency: instruction in ID at edge N appears on the ID/EX outputs after edge N+1.
- Load-use hazard: exactly LOAD_USE_STALLS bubbles, then the dependent instruction issues.
- o_pc_write, o_if_id_write and o_take_branch are combinational in the decode cycle.
- HALT: o_halt is high for exactly one cycle, then o_valid=0 thereafter.
- Reset asserted in STALL or HALTED returns to RUN on that edge. A pending debug request is dropped.
- Simultaneous hz and HALT decode: hz wins; the HALT issues after the stall.

## Test plan
- Reset, then ADDI r1,r0,5 with i_wb_write r1=5 two cycles later; then SW r1 → o_data_b=5. Read of r0 after a write of 7 to r0 → 0.
- LW r2 in EX (i_ex_mem_read=1, i_ex_rt=2), ADD r3,r2,r1 in ID, LOAD_USE_STALLS=3 → exactly 3 cycles of o_pc_write=0 and o_valid=0, then ADD issues with o_reg_dst=1.
- BEQ with i_fwd_a=1, i_fwd_data=9, rt data=9, i_pc=0x10, imm=−4 → o_take_branch=1, o_target=0x0C. Same with rt=8 → 0.
- J 0x3FF with i_enable=0 → o_take_branch=0. With i_enable=1 → o_target=0x3FF.
- HALT → one cycle of o_halt=1, then HALTED. Debug read r5=0xDEADBEEF → o_dbg_ack one cycle after req, o_dbg_data=0xDEADBEEF.
- Assert reset in HALTED with a pending debug request → all outputs 0, state RUN, no ack.
